fetch_unit: RTL and testbench

- IF stage of the 5-stage pipeline. Owns the PC, issues instruction-memory requests and accepts responses.
- Presents one instruction per slot (o_inst, o_PC, o_PC_plus_4, o_valid) to the IF/ID pipeline register, which captures them on the next clk edge.
- Honours the hazard-unit stall and the EX-stage redirect (taken branch/jump). Keeps at most one memory request outstanding and drops stale responses after a redirect.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch defaults and fetch FSM encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if
  import cpu_pkg::*;
();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps one imem request in flight, presents responses combinationally.
// Stall parks the presented word in a hold buffer; a redirect squashes the slot and any stale response.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PC_plus_4,
  output logic            o_valid
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] redirect_target;

  assign pc_plus_4       = pc + XLEN'(4);
  assign redirect_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  assign imem.imem_req_valid = (state == REQ) && !redirect_valid;
  assign imem.imem_req_addr  = pc;

  assign o_PC        = pc;
  assign o_PC_plus_4 = pc_plus_4;

  always_comb begin
    o_valid = 1'b0;
    o_inst  = NOP_INST;
    if (!redirect_valid) begin
      if (state == HOLD) begin
        o_valid = 1'b1;
        o_inst  = hold_inst;
      end else if (state == WAIT && imem.imem_rsp_valid) begin
        o_valid = 1'b1;
        o_inst  = imem.imem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      hold_inst <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_target;
      hold_inst <= '0;
      // An in-flight request must still return; remember to drop it.
      case (state)
        WAIT, DISCARD: state <= imem.imem_rsp_valid ? REQ : DISCARD;
        default:       state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem.imem_req_valid && imem.imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (stall) begin
              hold_inst <= imem.imem_rsp_data;
              state     <= HOLD;
            end else begin
              pc    <= pc_plus_4;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc        <= pc_plus_4;
            hold_inst <= '0;
            state     <= REQ;
          end
        end
        DISCARD: begin
          if (imem.imem_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // Memory must never answer when nothing is outstanding.
  assert property (@(posedge clk) disable iff (reset)
    !(imem.imem_rsp_valid && (state == REQ || state == HOLD)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable imem model plus directed scenarios.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] o_inst;
  logic [31:0] o_PC;
  logic [31:0] o_PC_plus_4;
  logic        o_valid;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem),
    .o_inst        (o_inst),
    .o_PC          (o_PC),
    .o_PC_plus_4   (o_PC_plus_4),
    .o_valid       (o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  int          checks   = 0;
  int          failures = 0;
  int          mem_lat  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hA0A0_A0A0;
      32'h0000_0004: return 32'hA1A1_A1A1;
      32'h0000_0008: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  // Single-outstanding memory: answers mem_lat cycles after acceptance, forgets on reset.
  logic [31:0] pend_addr;
  int          pend_cnt = 0;
  always @(posedge clk) begin : mem_model
    logic        acc;
    logic [31:0] a;
    acc = imem.imem_req_valid && imem.imem_req_ready && !reset;
    a   = imem.imem_req_addr;
    #1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    if (reset) pend_cnt = 0;
    if (acc) begin
      pend_addr = a;
      pend_cnt  = mem_lat;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = mem_word(pend_addr);
      end
    end
  end

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.pc4  = pc + 32'd4;
    e.inst = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  // Mid-cycle sample: log accepted requests and score every consumed instruction.
  task automatic at_sample();
    exp_t e;
    @(negedge clk);
    if (!reset && imem.imem_req_valid && imem.imem_req_ready) req_log.push_back(imem.imem_req_addr);
    if (!reset && o_valid && !stall) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction", o_PC, o_inst);
      end else begin
        e = sb.pop_front();
        if (o_PC !== e.pc || o_inst !== e.inst || o_PC_plus_4 !== e.pc4) begin
          failures++;
          $display("FAIL sb_fetch: got pc=%h pc4=%h inst=%h, required pc=%h pc4=%h inst=%h",
                   o_PC, o_PC_plus_4, o_inst, e.pc, e.pc4, e.inst);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      at_drive();
      at_sample();
    end
  endtask

  task automatic test_reset();
    repeat (2) at_drive();
    at_sample();
    checks += 6;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", o_valid); end
    if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst: got %h required 00000013", o_inst); end
    if (o_PC !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h required 00000000", o_PC); end
    if (o_PC_plus_4 !== 32'h4) begin failures++; $display("FAIL rst_pc4: got %h required 00000004", o_PC_plus_4); end
    if (imem.imem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid: got %b required 1", imem.imem_req_valid); end
    if (imem.imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr: got %h required 00000000", imem.imem_req_addr); end
  endtask

  task automatic test_basic();
    req_log.delete();
    mem_lat = 1;
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    at_drive();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      at_sample();
      if (req_log.size() >= 3) break;
      at_drive();
    end
    checks += 2;
    if (req_log.size() < 3) begin
      failures++;
      $display("FAIL basic_req_count: got %0d requests, required 3", req_log.size());
    end else if (req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL basic_req_addrs: got %h %h %h, required 0 4 8", req_log[0], req_log[1], req_log[2]);
    end
    if (sb.size() != 0) begin failures++; $display("FAIL basic_drain: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_stall();
    expect_fetch(32'h8);
    at_drive();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_sample();
      checks += 4;
      if (o_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b required 1", i, o_valid); end
      if (o_inst !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_inst[%0d]: got %h required deadbeef", i, o_inst); end
      if (o_PC !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d]: got %h required 00000008", i, o_PC); end
      if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_noreq[%0d]: got %b required 0", i, imem.imem_req_valid); end
      at_drive();
    end
    stall = 1'b0;
    at_sample();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL stall_release: %0d left, required 0", sb.size()); end
    at_drive();
    at_sample();
    checks++;
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'hC) begin
      failures++;
      $display("FAIL stall_next_req: got vld=%b addr=%h, required 1 0000000c", imem.imem_req_valid, imem.imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    at_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    at_sample();
    checks++;
    if (o_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdw_cycle: got valid=%b req=%b, required 0 0", o_valid, imem.imem_req_valid);
    end
    at_drive();
    redirect_valid = 1'b0;
    at_sample();
    checks++;
    if (o_PC !== 32'h100 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdw_target: got pc=%h valid=%b, required 00000100 0", o_PC, o_valid);
    end
    at_drive();
    at_sample();
    checks++;
    if (o_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdw_stale_rsp: got valid=%b req=%b, required 0 0", o_valid, imem.imem_req_valid);
    end
    req_log.delete();
    expect_fetch(32'h100);
    drain(12);
    checks += 2;
    if (sb.size() != 0) begin failures++; $display("FAIL rdw_drain: %0d left, required 0", sb.size()); end
    if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
      failures++;
      $display("FAIL rdw_req_addr: got %0d reqs first=%h, required 00000100", req_log.size(),
               req_log.size() > 0 ? req_log[0] : 32'hX);
    end
  endtask

  task automatic test_redirect_rsp_stall();
    mem_lat = 1;
    at_drive();
    at_sample();
    at_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    stall          = 1'b1;
    at_sample();
    checks++;
    if (o_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rrs_cycle: got valid=%b req=%b, required 0 0", o_valid, imem.imem_req_valid);
    end
    at_drive();
    redirect_valid = 1'b0;
    at_sample();
    checks += 2;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rrs_no_hold: got valid=%b required 0", o_valid); end
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL rrs_next_req: got vld=%b addr=%h, required 1 00000200", imem.imem_req_valid, imem.imem_req_addr);
    end
    expect_fetch(32'h200);
    at_drive();
    stall = 1'b0;
    at_sample();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rrs_drain: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_ready_low();
    at_drive();
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_sample();
      checks++;
      if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h204 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL ready_low[%0d]: got vld=%b addr=%h valid=%b, required 1 00000204 0",
                 i, imem.imem_req_valid, imem.imem_req_addr, o_valid);
      end
      at_drive();
    end
    imem.imem_req_ready = 1'b1;
    expect_fetch(32'h204);
    at_sample();
    drain(8);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL ready_drain: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    at_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    at_sample();
    checks++;
    if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL wrap_req_blocked: got %b required 0", imem.imem_req_valid); end
    at_drive();
    redirect_valid = 1'b0;
    expect_fetch(32'hFFFF_FFFC);
    at_sample();
    checks++;
    if (o_PC !== 32'hFFFF_FFFC || o_PC_plus_4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc4: got pc=%h pc4=%h, required fffffffc 00000000", o_PC, o_PC_plus_4);
    end
    drain(8);
    at_drive();
    at_sample();
    checks += 2;
    if (sb.size() != 0) begin failures++; $display("FAIL wrap_drain: %0d left, required 0", sb.size()); end
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next_req: got vld=%b addr=%h, required 1 00000000", imem.imem_req_valid, imem.imem_req_addr);
    end
  endtask

  task automatic test_async_reset();
    expect_fetch(32'h0);
    at_drive();
    at_sample();
    at_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    at_sample();
    at_drive();
    redirect_valid = 1'b0;
    mem_lat        = 3;
    at_sample();
    checks++;
    if (imem.imem_req_addr !== 32'h300 || sb.size() != 0) begin
      failures++;
      $display("FAIL ar_setup: got addr=%h pending=%0d, required 00000300 0", imem.imem_req_addr, sb.size());
    end
    at_drive();
    #1;
    reset = 1'b1;
    #1;
    checks += 5;
    if (o_PC !== 32'h0) begin failures++; $display("FAIL ar_pc: got %h required 00000000", o_PC); end
    if (o_PC_plus_4 !== 32'h4) begin failures++; $display("FAIL ar_pc4: got %h required 00000004", o_PC_plus_4); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL ar_valid: got %b required 0", o_valid); end
    if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL ar_inst: got %h required 00000013", o_inst); end
    if (imem.imem_req_valid !== 1'b1) begin failures++; $display("FAIL ar_req_valid: got %b required 1", imem.imem_req_valid); end
    at_drive();
    at_drive();
    mem_lat = 1;
    req_log.delete();
    expect_fetch(32'h0);
    reset = 1'b0;
    at_sample();
    drain(8);
    checks += 2;
    if (sb.size() != 0) begin failures++; $display("FAIL ar_drain: %0d left, required 0", sb.size()); end
    if (req_log.size() == 0 || req_log[0] !== 32'h0) begin
      failures++;
      $display("FAIL ar_first_req: got %0d reqs, required first addr 00000000", req_log.size());
    end
  endtask

  initial begin
    reset               = 1'b1;
    stall               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem.imem_req_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_stall();
    test_ready_low();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
